ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/ifetch_unit.sv | 98 +++++++++
 tb/tb_ifetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_unit_pkg : shared fetch-path types and constants
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ifetch_unit_pkg;

    localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;
    localparam int          ENTRY_W      = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    // Buffer entry layout: instruction word in the upper half, its address below.
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [31:0] word,
                                                      input logic [31:0] addr);
        return {word, addr};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo : DEPTH-entry FIFO with wrap-around pointers and same-cycle flush
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head,
    output logic                     valid
);

    localparam int                PTR_W  = $clog2(DEPTH);
    localparam int                CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0]  C_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // A pop frees the head slot, so a push alongside it is legal even when full.
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != C_FULL) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];
    assign valid = (r_count != '0);

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit : single-outstanding instruction fetch with flush and fetch buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = CPU_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    output logic        pc_hold,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        dec_ready
);

    localparam int               CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    fetch_state_t       r_state;
    logic [31:0]        r_addr;
    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_head;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;

    // rst_n gates the combinational outputs so they sit at reset values immediately.
    assign w_issue   = rst_n && (r_state == IDLE) && (w_count < C_FULL) && !flush;
    assign pc_hold   = !(w_issue || (flush && rst_n));
    assign imem_req  = w_issue;
    assign imem_addr = w_issue ? pc : 32'h0;

    assign w_push = (r_state == WAIT) && imem_ack && !flush;
    assign w_pop  = inst_valid && dec_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= RESET_PC;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_addr  <= pc;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        r_state <= imem_ack ? IDLE : DROP;
                    end else if (imem_ack) begin
                        r_state <= IDLE;
                    end
                end
                DROP: begin
                    // The ack retires the only outstanding request, flush or not.
                    if (imem_ack) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (w_push),
        .push_data (pack_entry(imem_rdata, r_addr)),
        .pop       (w_pop),
        .count     (w_count),
        .head      (w_head),
        .valid     (inst_valid)
    );

    assign inst    = w_head[63:32];
    assign inst_pc = w_head[31:0];

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit : scoreboard bench with randomized memory latency and flushes
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic        pc_hold;
    logic        flush = 1'b0;
    logic [31:0] target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        dec_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state: fetch stream, one memory transaction, expected buffer.
    logic [63:0] exp_q[$];
    logic [31:0] next_addr = RESET_PC;
    logic [31:0] out_addr = 32'h0;
    bit          outstanding = 0;
    bit          doomed = 0;
    bit          late_ack = 0;
    int          cnt = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;

    ifetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .pc_hold    (pc_hold),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .dec_ready  (dec_ready)
    );

    always #5 clk = ~clk;

    // Program-counter register controlled by the unit's hold output.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pc <= RESET_PC;
        else if (!pc_hold) pc <= flush ? target : pc + 32'd4;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit fl, input logic [31:0] tgt, input bit rdy);
        bit ack_now;
        bit exp_req;
        @(negedge clk);
        rst_n      = 1'b1;
        flush      = fl;
        target     = tgt;
        dec_ready  = rdy;
        ack_now    = 0;
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (outstanding) begin
            cnt--;
            if (cnt == 0) begin
                ack_now    = 1;
                imem_ack   = 1'b1;
                imem_rdata = mem_word(out_addr);
            end
        end else if (late_ack) begin
            imem_ack = 1'b1;
            late_ack = 0;
        end
        #1;
        exp_req = !outstanding && (exp_q.size() < DEPTH) && !fl;
        chk("imem_req", imem_req, exp_req);
        chk("pc_hold", pc_hold, !(exp_req || fl));
        if (exp_req && imem_req) chk("imem_addr", imem_addr, next_addr);
        #2;
        if (ack_now) begin
            if (!doomed && !fl) exp_q.push_back({mem_word(out_addr), out_addr});
            outstanding = 0;
        end
        if (fl) begin
            exp_q.delete();
            next_addr = tgt;
            if (outstanding) doomed = 1;
        end
        if (exp_req) begin
            outstanding = 1;
            doomed      = 0;
            cnt         = $urandom_range(lat_lo, lat_hi);
            out_addr    = next_addr;
            next_addr   = next_addr + 32'd4;
        end
    endtask

    task automatic step_until_outstanding(input bit rdy);
        for (int i = 0; i < 10 && !outstanding; i++) step(1'b0, 32'h0, rdy);
        checks++;
        if (!outstanding) begin
            errors++;
            $display("FAIL issue_timeout: got no request expected one within 10 cycles");
        end
    endtask

    task automatic reset_check();
        @(negedge clk);
        rst_n     = 1'b0;
        flush     = 1'b0;
        imem_ack  = 1'b0;
        dec_ready = 1'b0;
        #1;
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_pc_hold", pc_hold, 1'b1);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        exp_q.delete();
        outstanding = 0;
        doomed      = 0;
        next_addr   = RESET_PC;
        repeat (2) @(posedge clk);
    endtask

    // Monitor: compares the buffer head whenever decode would take it.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("inst_valid", inst_valid, exp_q.size() != 0);
                if (exp_q.size() != 0 && dec_ready && !flush) begin
                    e = exp_q.pop_front();
                    chk("inst", inst, e[63:32]);
                    chk("inst_pc", inst_pc, e[31:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        reset_check();

        // Streaming with one-cycle memory: 3000, 3004, 3008 ... every other cycle.
        lat_lo = 1; lat_hi = 1;
        repeat (12) step(1'b0, 32'h0, 1'b1);

        // Decode stalled: buffer fills to DEPTH and fetching stops.
        repeat (12) step(1'b0, 32'h0, 1'b0);

        // Flush while waiting; the late response is dropped, refetch from 3100.
        lat_lo = 3; lat_hi = 3;
        repeat (4) step(1'b0, 32'h0, 1'b1);
        step_until_outstanding(1'b1);
        step(1'b1, 32'h0000_3100, 1'b1);
        repeat (10) step(1'b0, 32'h0, 1'b1);

        // Flush coincident with the ack.
        lat_lo = 1; lat_hi = 1;
        step_until_outstanding(1'b1);
        step(1'b1, 32'h0000_3200, 1'b1);
        repeat (8) step(1'b0, 32'h0, 1'b1);

        // Sustained push/pop traffic with the buffer kept busy.
        repeat (16) step(1'b0, 32'h0, 1'b1);

        // Reset in the middle of a wait with a non-empty buffer, then a stray ack.
        lat_lo = 4; lat_hi = 4;
        repeat (6) step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        step_until_outstanding(1'b0);
        step(1'b0, 32'h0, 1'b0);
        reset_check();
        late_ack = 1;
        lat_lo = 1; lat_hi = 3;
        repeat (12) step(1'b0, 32'h0, 1'b1);

        // Randomized traffic.
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) == 0, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 3) != 0);
        end
        repeat (20) step(1'b0, 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
